// File: rtl/rect_filler_pkg.sv
// Shared types and helpers for the rectangle filler: FSM states, burst geometry
// and the MIG address-FIFO packing.
package fill_pkg;

    typedef enum logic [1:0] {IDLE, WRITE1, WRITE2, DONE} state_t;

    localparam int BURST_PIX = 8;
    localparam int WORD_PIX  = 4;
    localparam int PIX_BYTES = 4;

    // MIG takes the 32-byte-aligned burst address shifted into a 31-bit field
    function automatic logic [30:0] mig_addr(input logic [31:0] byte_addr);
        return {6'b0, byte_addr[27:5], 2'b00};
    endfunction

endpackage

// File: rtl/rect_filler_burst_mask_gen.sv
// Byte mask for one 128-bit word of an 8-pixel burst: pixels outside [x0, x1]
// get all four of their byte-mask bits set.
module burst_mask_gen
    import fill_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-4:0]              bx,
    input  logic [COORD_W-1:0]              x0,
    input  logic [COORD_W-1:0]              x1,
    input  logic                            word_sel,
    output logic [WORD_PIX*PIX_BYTES-1:0]   mask
);

    logic [COORD_W-1:0] col;

    always_comb begin
        mask = '0;
        col  = '0;
        for (int p = 0; p < WORD_PIX; p++) begin
            col = {bx, word_sel, 2'(p)};
            if (col < x0 || col > x1)
                mask[p*PIX_BYTES +: PIX_BYTES] = '1;
        end
    end

endmodule

// File: rtl/rect_filler.sv
// Fills the whole framebuffer or a clipped rectangle with one colour using
// 2-word DDR2 write bursts through the MIG address and write-data FIFOs.
module rect_filler
    import fill_pkg::*;
#(
    parameter logic [9:0] FB_BASE   = 10'b0001000001,
    parameter int         FB_WIDTH  = 800,
    parameter int         FB_HEIGHT = 600,
    parameter int         COORD_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic               mode,
    input  logic [23:0]        color,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               af_full,
    input  logic               wdf_full,
    output logic [30:0]        af_addr_din,
    output logic               af_wr_en,
    output logic [127:0]       wdf_din,
    output logic [15:0]        wdf_mask_din,
    output logic               wdf_wr_en,
    output logic               ready,
    output logic               done
);

    localparam int                 BX_W  = COORD_W - 3;
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(FB_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(FB_HEIGHT - 1);

    state_t             state;
    logic [COORD_W-1:0] x0_r, x1_r, y1_r, cur_y;
    logic [BX_W-1:0]    row_start, row_end, cur_bx;

    logic [COORD_W-1:0] cx0, cx1, cy0, cy1;
    logic               cmd_empty;
    logic [COORD_W-1:0] adv_y;
    logic [BX_W-1:0]    adv_bx;
    logic               adv_last;
    logic [BX_W-1:0]    mg_bx;
    logic [COORD_W-1:0] mg_x0, mg_x1;
    logic               mg_word;
    logic [15:0]        mg_mask;

    function automatic logic [30:0] burst_addr(input logic [COORD_W-1:0] y,
                                               input logic [BX_W-1:0]    bx);
        return mig_addr({FB_BASE, y, bx, 5'b0});
    endfunction

    always_comb begin
        cx0 = '0;
        cy0 = '0;
        cx1 = X_MAX;
        cy1 = Y_MAX;
        if (mode) begin
            cx0 = x0;
            cy0 = y0;
            cx1 = (x1 > X_MAX) ? X_MAX : x1;
            cy1 = (y1 > Y_MAX) ? Y_MAX : y1;
        end
        cmd_empty = (cx0 > cx1) || (cy0 > cy1);
    end

    always_comb begin
        adv_bx   = cur_bx;
        adv_y    = cur_y;
        adv_last = 1'b0;
        if (cur_bx < row_end) begin
            adv_bx = cur_bx + 1'b1;
        end else if (cur_y < y1_r) begin
            adv_y  = cur_y + 1'b1;
            adv_bx = row_start;
        end else begin
            adv_last = 1'b1;
        end
    end

    // The mask generator always looks at the word that will be presented next
    always_comb begin
        mg_bx   = adv_bx;
        mg_x0   = x0_r;
        mg_x1   = x1_r;
        mg_word = 1'b0;
        case (state)
            IDLE: begin
                mg_bx = cx0[COORD_W-1:3];
                mg_x0 = cx0;
                mg_x1 = cx1;
            end
            WRITE1: begin
                mg_bx   = cur_bx;
                mg_word = 1'b1;
            end
            default: ;
        endcase
    end

    burst_mask_gen #(.COORD_W(COORD_W)) u_mask (
        .bx       (mg_bx),
        .x0       (mg_x0),
        .x1       (mg_x1),
        .word_sel (mg_word),
        .mask     (mg_mask)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            ready        <= 1'b1;
            done         <= 1'b0;
            af_wr_en     <= 1'b0;
            wdf_wr_en    <= 1'b0;
            wdf_mask_din <= '0;
            cur_y        <= '0;
            cur_bx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        x0_r      <= cx0;
                        x1_r      <= cx1;
                        y1_r      <= cy1;
                        row_start <= cx0[COORD_W-1:3];
                        row_end   <= cx1[COORD_W-1:3];
                        ready     <= 1'b0;
                        if (cmd_empty) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= WRITE1;
                            af_wr_en     <= 1'b1;
                            wdf_wr_en    <= 1'b1;
                            cur_y        <= cy0;
                            cur_bx       <= cx0[COORD_W-1:3];
                            af_addr_din  <= burst_addr(cy0, cx0[COORD_W-1:3]);
                            wdf_din      <= {4{8'h00, color}};
                            wdf_mask_din <= mg_mask;
                        end
                    end
                end
                WRITE1: begin
                    if (!af_full && !wdf_full) begin
                        state        <= WRITE2;
                        af_wr_en     <= 1'b0;
                        wdf_mask_din <= mg_mask;
                    end
                end
                WRITE2: begin
                    if (!wdf_full) begin
                        if (adv_last) begin
                            state        <= DONE;
                            wdf_wr_en    <= 1'b0;
                            wdf_mask_din <= '0;
                            done         <= 1'b1;
                        end else begin
                            state        <= WRITE1;
                            af_wr_en     <= 1'b1;
                            cur_y        <= adv_y;
                            cur_bx       <= adv_bx;
                            af_addr_din  <= burst_addr(adv_y, adv_bx);
                            wdf_mask_din <= mg_mask;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_filler.sv
// Self-checking bench for rect_filler on a reduced 160x120 framebuffer, with a
// pixel-level reference model of the bursts each command must produce.
module tb_rect_filler;

    localparam logic [9:0] FB_BASE = 10'b0001000001;
    localparam int FBW = 160;
    localparam int FBH = 120;
    localparam int CW  = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           valid = 1'b0;
    logic           mode = 1'b0;
    logic [23:0]    color = '0;
    logic [CW-1:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic           af_full = 1'b0, wdf_full = 1'b0;
    logic [30:0]    af_addr_din;
    logic           af_wr_en;
    logic [127:0]   wdf_din;
    logic [15:0]    wdf_mask_din;
    logic           wdf_wr_en, ready, done;

    rect_filler #(.FB_BASE(FB_BASE), .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst), .valid(valid), .mode(mode), .color(color),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .af_full(af_full), .wdf_full(wdf_full),
        .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
        .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
        .ready(ready), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Observed FIFO traffic and protocol bookkeeping
    logic [30:0]  q_addr[$];
    logic [127:0] q_data[$];
    logic [15:0]  q_mask[$];
    int cyc = 0, done_cnt = 0, done_cyc = 0;
    int stab_err = 0, order_err = 0, both_err = 0;
    logic hold1 = 1'b0, hold2 = 1'b0;
    logic [30:0] p_addr;
    logic [127:0] p_data;
    logic [15:0] p_mask;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            hold1 <= 1'b0;
            hold2 <= 1'b0;
        end else begin
            if (hold1 && (!af_wr_en || !wdf_wr_en || af_addr_din !== p_addr ||
                          wdf_din !== p_data || wdf_mask_din !== p_mask))
                stab_err <= stab_err + 1;
            if (hold2 && (af_wr_en || !wdf_wr_en || wdf_din !== p_data || wdf_mask_din !== p_mask))
                stab_err <= stab_err + 1;
            hold1  <= af_wr_en && (af_full || wdf_full);
            hold2  <= wdf_wr_en && !af_wr_en && wdf_full;
            p_addr <= af_addr_din;
            p_data <= wdf_din;
            p_mask <= wdf_mask_din;
            if (af_wr_en && !wdf_wr_en) order_err <= order_err + 1;
            if (af_wr_en && !af_full && !wdf_full) begin
                q_addr.push_back(af_addr_din);
                q_data.push_back(wdf_din);
                q_mask.push_back(wdf_mask_din);
            end
            if (wdf_wr_en && !af_wr_en && !wdf_full) begin
                if (q_mask.size() >= 2 * q_addr.size()) order_err <= order_err + 1;
                q_data.push_back(wdf_din);
                q_mask.push_back(wdf_mask_din);
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (done && ready) both_err <= both_err + 1;
        end
    end

    // Reference model: expected burst addresses and word masks for a command
    logic [30:0] e_addr[$];
    logic [15:0] e_mask[$];

    function automatic logic [30:0] exp_af(input int y, input int bx);
        longint a;
        a = (longint'(FB_BASE) << 22) + (longint'(y) << 12) + (longint'(bx) << 5);
        return 31'(((a >> 5) & 64'h7FFFFF) << 2);
    endfunction

    function automatic logic [15:0] exp_mask(input int bx, input int half, input int lo, input int hi);
        logic [15:0] m;
        int col;
        m = '0;
        for (int p = 0; p < 4; p++) begin
            col = bx * 8 + half * 4 + p;
            if (col < lo || col > hi) m = m | (16'hF << (4 * p));
        end
        return m;
    endfunction

    task automatic build_expected(input logic m, input int ax0, input int ay0, input int ax1, input int ay1);
        int lx, ly, hx, hy;
        e_addr.delete();
        e_mask.delete();
        if (m) begin
            lx = ax0; ly = ay0;
            hx = (ax1 > FBW - 1) ? FBW - 1 : ax1;
            hy = (ay1 > FBH - 1) ? FBH - 1 : ay1;
        end else begin
            lx = 0; ly = 0; hx = FBW - 1; hy = FBH - 1;
        end
        if (lx > hx || ly > hy) return;
        for (int y = ly; y <= hy; y++)
            for (int bx = lx / 8; bx <= hx / 8; bx++) begin
                e_addr.push_back(exp_af(y, bx));
                e_mask.push_back(exp_mask(bx, 0, lx, hx));
                e_mask.push_back(exp_mask(bx, 1, lx, hx));
            end
    endtask

    task automatic clear_obs();
        q_addr.delete();
        q_data.delete();
        q_mask.delete();
    endtask

    task automatic send_cmd(input logic m, input logic [23:0] c, input int ax0, input int ay0,
                            input int ax1, input int ay1, output int acc_cyc);
        for (int i = 0; i < 20 && !ready; i++) begin
            @(posedge clk); #1;
        end
        mode = m; color = c;
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        valid = 1'b1;
        acc_cyc = cyc;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input bit bp, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (bp) begin
                af_full  = ($urandom_range(0, 2) == 0);
                wdf_full = ($urandom_range(0, 2) == 0);
            end
        end
        if (done_cnt >= target) ok = 1'b1;
        af_full  = 1'b0;
        wdf_full = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({ready, done, af_wr_en, wdf_wr_en, wdf_mask_din} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b done=%b af=%b wdf=%b mask=%h want 1 0 0 0 0000",
                     ready, done, af_wr_en, wdf_wr_en, wdf_mask_din);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        int acc, base, bad_mask, bad_data, bad_addr;
        bit ok;
        logic [127:0] want_data;
        base = done_cnt;
        clear_obs();
        build_expected(1'b0, 0, 0, 0, 0);
        send_cmd(1'b0, 24'h123456, $urandom_range(0, 50), $urandom_range(0, 50), 3, 2, acc);
        wait_done(base + 1, 2 * e_addr.size() + 50, 1'b0, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL full_done_timeout: got no done want done"); end
        vectors++;
        if (q_addr.size() != FBW / 8 * FBH) begin
            miscompares++; $display("FAIL full_af_count: got %0d want %0d", q_addr.size(), FBW / 8 * FBH);
        end
        vectors++;
        if (q_mask.size() != FBW / 4 * FBH) begin
            miscompares++; $display("FAIL full_wdf_count: got %0d want %0d", q_mask.size(), FBW / 4 * FBH);
        end
        want_data = {4{32'h00123456}};
        bad_mask = 0; bad_data = 0; bad_addr = 0;
        foreach (q_mask[i]) if (q_mask[i] !== 16'h0) bad_mask++;
        foreach (q_data[i]) if (q_data[i] !== want_data) bad_data++;
        foreach (q_addr[i]) if (i >= e_addr.size() || q_addr[i] !== e_addr[i]) bad_addr++;
        vectors++;
        if (bad_mask != 0) begin miscompares++; $display("FAIL full_masks: got %0d nonzero want 0", bad_mask); end
        vectors++;
        if (bad_data != 0) begin miscompares++; $display("FAIL full_data: got %0d wrong words want 0", bad_data); end
        vectors++;
        if (bad_addr != 0) begin miscompares++; $display("FAIL full_addr_seq: got %0d wrong want 0", bad_addr); end
        if (q_addr.size() > 0) begin
            vectors++;
            if (q_addr[0] !== exp_af(0, 0)) begin
                miscompares++; $display("FAIL full_first_addr: got %h want %h", q_addr[0], exp_af(0, 0));
            end
            vectors++;
            if (q_addr[$] !== exp_af(FBH - 1, FBW / 8 - 1)) begin
                miscompares++; $display("FAIL full_last_addr: got %h want %h", q_addr[$], exp_af(FBH - 1, FBW / 8 - 1));
            end
        end
        vectors++;
        if (done_cnt != base + 1) begin
            miscompares++; $display("FAIL full_done_count: got %0d want 1", done_cnt - base);
        end
    endtask

    task automatic test_rect_masks();
        int acc, base;
        bit ok;
        logic [15:0] want [4];
        base = done_cnt;
        clear_obs();
        build_expected(1'b1, 3, 10, 12, 11);
        send_cmd(1'b1, 24'hA5C3E1, 3, 10, 12, 11, acc);
        wait_done(base + 1, 100, 1'b0, ok);
        vectors++;
        if (!ok || q_addr.size() != 4) begin
            miscompares++; $display("FAIL rect_burst_count: got %0d want 4 (done=%0b)", q_addr.size(), ok);
        end else begin
            want = '{16'h0FFF, 16'h0000, 16'h0000, 16'hFFF0};
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (q_mask[i] !== want[i]) begin
                    miscompares++; $display("FAIL rect_mask_%0d: got %h want %h", i, q_mask[i], want[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (q_addr[i] !== exp_af(10 + i / 2, i % 2)) begin
                    miscompares++; $display("FAIL rect_addr_%0d: got %h want %h", i, q_addr[i], exp_af(10 + i / 2, i % 2));
                end
            end
        end
    endtask

    task automatic test_empty_rect();
        int acc, base;
        bit ok;
        base = done_cnt;
        clear_obs();
        send_cmd(1'b1, 24'h00FF00, 900, 20, 950, 30, acc);
        wait_done(base + 1, 10, 1'b0, ok);
        vectors++;
        if (!ok || q_addr.size() != 0 || q_mask.size() != 0) begin
            miscompares++; $display("FAIL empty_writes: got af=%0d wdf=%0d done=%0b want 0 0 1", q_addr.size(), q_mask.size(), ok);
        end
        vectors++;
        if (done_cyc - acc < 1 || done_cyc - acc > 2) begin
            miscompares++; $display("FAIL empty_done_latency: got %0d want 1..2", done_cyc - acc);
        end
        vectors++;
        if (ready !== 1'b1 || done_cnt != base + 1) begin
            miscompares++; $display("FAIL empty_ready: got rdy=%b dones=%0d want 1 1", ready, done_cnt - base);
        end
    endtask

    task automatic test_backpressure();
        int acc, base, ax0, ay0, ax1, ay1, bad;
        bit ok;
        logic [23:0] c;
        for (int r = 0; r < 6; r++) begin
            if (r == 0) begin
                ax0 = 5; ay0 = 7; ax1 = 21; ay1 = 9;
            end else begin
                ax0 = $urandom_range(0, FBW + 10); ax1 = ax0 + $urandom_range(0, 40);
                ay0 = $urandom_range(0, FBH + 2);  ay1 = ay0 + $urandom_range(0, 3);
            end
            c = 24'($urandom);
            base = done_cnt;
            clear_obs();
            build_expected(1'b1, ax0, ay0, ax1, ay1);
            send_cmd(1'b1, c, ax0, ay0, ax1, ay1, acc);
            wait_done(base + 1, 8 * e_addr.size() + 100, 1'b1, ok);
            bad = 0;
            if (q_addr.size() != e_addr.size() || q_mask.size() != e_mask.size()) bad++;
            else begin
                foreach (e_addr[i]) if (q_addr[i] !== e_addr[i]) bad++;
                foreach (e_mask[i]) if (q_mask[i] !== e_mask[i] || q_data[i] !== {4{8'h00, c}}) bad++;
            end
            vectors++;
            if (!ok || bad != 0) begin
                miscompares++;
                $display("FAIL bp_rect_%0d: got af=%0d wdf=%0d bad=%0d done=%0b want af=%0d wdf=%0d bad=0",
                         r, q_addr.size(), q_mask.size(), bad, ok, e_addr.size(), e_mask.size());
            end
            vectors++;
            if (2 * q_addr.size() != q_mask.size()) begin
                miscompares++; $display("FAIL bp_ratio_%0d: got af=%0d wdf=%0d want wdf=2*af", r, q_addr.size(), q_mask.size());
            end
        end
        vectors++;
        if (stab_err != 0 || order_err != 0 || both_err != 0) begin
            miscompares++; $display("FAIL bp_protocol: got stab=%0d order=%0d both=%0d want 0 0 0", stab_err, order_err, both_err);
        end
    endtask

    task automatic test_reset_mid();
        int acc, base, bad;
        bit hit, ok;
        hit = 1'b0;
        clear_obs();
        send_cmd(1'b0, 24'h777777, 0, 0, 0, 0, acc);
        for (int i = 0; i < 2 * (FBW / 8) * 7 + 50; i++) begin
            if (af_wr_en && af_addr_din === exp_af(5, 3)) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL rstmid_reach_row5: got no row-5 burst want one"); end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({af_wr_en, wdf_wr_en, ready, done} !== 4'b0010) begin
            miscompares++; $display("FAIL rstmid_outputs: got af=%b wdf=%b rdy=%b done=%b want 0 0 1 0",
                                    af_wr_en, wdf_wr_en, ready, done);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        base = done_cnt;
        clear_obs();
        build_expected(1'b1, 40, 50, 60, 52);
        send_cmd(1'b1, 24'h0A0B0C, 40, 50, 60, 52, acc);
        wait_done(base + 1, 100, 1'b0, ok);
        bad = 0;
        if (q_addr.size() != e_addr.size()) bad++;
        else foreach (e_addr[i]) if (q_addr[i] !== e_addr[i] || q_mask[2*i] !== e_mask[2*i]) bad++;
        vectors++;
        if (!ok || bad != 0 || q_addr.size() == 0 || q_addr[0] !== exp_af(50, 5)) begin
            miscompares++; $display("FAIL rstmid_restart: got bursts=%0d bad=%0d done=%0b want bursts=%0d bad=0",
                                    q_addr.size(), bad, ok, e_addr.size());
        end
    endtask

    task automatic test_valid_held();
        int base;
        bit ok, seen;
        base = done_cnt;
        clear_obs();
        build_expected(1'b1, 17, 2, 30, 3);
        mode = 1'b1; color = 24'h314159;
        x0 = CW'(17); y0 = CW'(2); x1 = CW'(30); y1 = CW'(3);
        valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen || q_addr.size() != e_addr.size()) begin
            miscompares++; $display("FAIL held_first: got bursts=%0d done=%0b want bursts=%0d", q_addr.size(), seen, e_addr.size());
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (af_wr_en !== 1'b1 || af_addr_din !== e_addr[0]) begin
            miscompares++; $display("FAIL held_second_accept: got af=%b addr=%h want 1 %h", af_wr_en, af_addr_din, e_addr[0]);
        end
        valid = 1'b0;
        wait_done(base + 2, 100, 1'b0, ok);
        vectors++;
        if (!ok || done_cnt != base + 2 || q_addr.size() != 2 * e_addr.size()) begin
            miscompares++; $display("FAIL held_total: got dones=%0d bursts=%0d want 2 %0d",
                                    done_cnt - base, q_addr.size(), 2 * e_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_rect_masks();
        test_empty_rect();
        test_backpressure();
        test_reset_mid();
        test_valid_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rect_filler.md
# rect_filler

Parametrised successor to the full-frame filler: fills either the whole framebuffer or a clipped rectangle with one 24-bit colour. It issues 2-word (256-bit, 8-pixel) DDR2 write bursts through the MIG address/write-data FIFOs and masks edge pixels per byte. Rows stream back-to-back without returning to idle. It sits between the graphics command decoder and the DDR2 arbiter's fill port.

## Interface
- FB_BASE, 10'b0001000001, address bits [31:22] of the framebuffer
- FB_WIDTH, 800, pixels per row; multiple of 8, ≤ 1024
- FB_HEIGHT, 600, rows; ≤ 1024
- COORD_W, 10, coordinate width
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset (reset when 0 at a clk edge)
- valid  input  1  command valid
- mode  input  1  0 = full frame, 1 = rectangle
- color  input  24  fill colour {R,G,B}
- x0, y0, x1, y1  input  COORD_W each  inclusive rectangle corners; ignored when mode=0
- af_full, wdf_full  input  1  MIG FIFO full flags
- af_addr_din  output  31  burst address
- af_wr_en  output  1  address FIFO write
- wdf_din  output  128  data word
- wdf_mask_din  output  16  byte mask; 1 = byte not written
- wdf_wr_en  output  1  data FIFO write
- ready  output  1  idle, can accept a command
- done  output  1  one-cycle pulse when a command completes

## Operation
- Accept a command on valid && ready. Capture colour as {8'b0,color}×4, plus mode and corners.
- Mode 0 uses rectangle (0,0)–(FB_WIDTH-1, FB_HEIGHT-1).
- Clipping: x1 clamped to FB_WIDTH-1, y1 clamped to FB_HEIGHT-1. If x0>x1 or y0>y1 after clamping, the rectangle is empty: no FIFO writes, done pulses.
- Cursor: row y, burst column bx = x>>3. Row start is x0>>3, row end is x1>>3.
- Address: addr = {FB_BASE, y, bx, 3'b000, 2'b00}; af_addr_din = {6'b0, addr[27:5], 2'b00}.
- Burst pixel p (0..7) = x-column bx*8+p, occupying bytes 4p..4p+3. Word 1 carries p=0..3 and word 2 carries p=4..7. Pixel p%4 maps to mask bits [4(p%4)+3 : 4(p%4)].
- A pixel is masked (4 bits set) when its column < x0 or > x1. Interior bursts have mask 16'h0000.
- States:
  - IDLE: ready=1. valid goes to WRITE1, or to DONE if the rectangle is empty.
  - WRITE1: af_wr_en=1, wdf_wr_en=1, word 1. Go to WRITE2 when !af_full && !wdf_full, else hold.
  - WRITE2: wdf_wr_en=1, word 2. When !wdf_full, advance the cursor and go to WRITE1, or to DONE after the last burst; else hold.
  - DONE: done=1 for one cycle, then IDLE.
- Cursor advance: bx < row end → bx+1; else y < y1 → y+1, bx = row start; else last burst.
- valid outside IDLE is ignored. The command is not queued.

## Timing
- Reset values: state IDLE, ready=1, done=0, af_wr_en=0, wdf_wr_en=0, wdf_mask_din=0, cursor=0.
- Reset mid-command: the command is abandoned. IDLE starts the next cycle; outputs take reset values the cycle after the rst=0 edge. Partial bursts are not completed.
- Outputs are decoded from state and registers. No combinational path runs from af_full or wdf_full to the enables.
- valid sampled at edge N → WRITE1 visible in cycle N+1.
- Without backpressure, each burst takes 2 cycles. A command of B bursts occupies WRITE states for 2B cycles; DONE follows, then ready=1 the cycle after.
- Full frame at defaults: 60000 bursts, 120000 write cycles.
- The address FIFO is written exactly once per burst, always together with word 1. Word 2 never precedes its address.
- Backpressure in WRITE1 holds both enables and all outputs stable. Backpressure in WRITE2 holds word 2 stable.
- done and ready are never both high.

## Structure
- Package fill_pkg holds:
  - state enum {IDLE, WRITE1, WRITE2, DONE}
  - localparams BURST_PIX=8, WORD_PIX=4, PIX_BYTES=4
  - the MIG address-packing function
- Sub-module burst_mask_gen (combinational): inputs bx, x0, x1, word select; output 16-bit mask.
- Top level holds the FSM, cursor counters, clamp/empty logic and command registers.

## Test plan
- mode=0, color=24'h123456, no backpressure:
  - 60000 af writes and 120000 wdf writes
  - all masks 0
  - wdf_din = 128'h00123456 repeated
  - first address has y=0, bx=0; last has y=599, bx=99
  - done once
- mode=1, (3,10)–(12,11):
  - bursts bx=0,1 on rows 10 and 11, 4 bursts total
  - bx=0 masks: word 1 16'h0FFF, word 2 16'h0000
  - bx=1 masks: word 1 16'h0000, word 2 16'hFFF0
- mode=1, x0=900, x1=950: zero FIFO writes, done 2 cycles after accept, ready restored.
- Random af_full/wdf_full toggling during a 3×3 rectangle: enables and data stable while full; no lost or duplicated words; address count equals word count / 2.
- rst=0 during row 5 of a full fill: enables low the next cycle, ready=1; a new command restarts cleanly at its own origin.
- valid held high throughout a command: exactly one command accepted; a second is accepted only after done.
